// File: rtl/i2c_target_if.sv
// I2C target bus-side and host-side signal bundle.
// slave: the target's view. master: the bus model / host driving it.
interface i2c_target_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       start_det;
  logic       stop_det;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, start_det, stop_det, busy
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address
// match, byte write strobe and byte read fetch. SDA is open-drain:
// sda_oe=1 pulls the line low.
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  i2c_target_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_c, stop_c;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [6:0] sh_q;      // 7 bits suffice: 8th bit is consumed/driven directly
  logic       rw_q;
  logic       byte_q;    // full byte seen, waiting for the scl_fall that opens the ACK slot
  logic       sda_oe_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q, tx_req_q, start_det_q, stop_det_q, busy_q;

  // Synchronizer chain plus one history flop per line; idle bus reads high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise =  scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s &  scl_hist_q;
  // SCL must be high on both samples so an SCL edge never aliases into START/STOP.
  assign start_c  = scl_s & scl_hist_q &  sda_hist_q & ~sda_s;
  assign stop_c   = scl_s & scl_hist_q & ~sda_hist_q &  sda_s;

  // Protocol FSM with registered outputs; START/STOP override bit handling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      sh_q        <= 7'd0;
      rw_q        <= 1'b0;
      byte_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      if (start_c) begin
        state_q     <= S_ADDR;
        cnt_q       <= 3'd0;
        byte_q      <= 1'b0;
        sda_oe_q    <= 1'b0;
        start_det_q <= 1'b1;
        busy_q      <= 1'b1;
      end else if (stop_c) begin
        state_q    <= S_IDLE;
        byte_q     <= 1'b0;
        sda_oe_q   <= 1'b0;
        stop_det_q <= 1'b1;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_ADDR: begin
            if (scl_rise && !byte_q) begin
              sh_q  <= {sh_q[5:0], sda_s};
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                // sh_q holds the 7 address bits; sda_s is R/W.
                if (sh_q == ADDR) begin
                  rw_q   <= sda_s;
                  byte_q <= 1'b1;
                end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end else if (scl_fall && byte_q) begin
              byte_q   <= 1'b0;
              sda_oe_q <= 1'b1;
              tx_req_q <= rw_q;
              state_q  <= S_ADDR_ACK;
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              cnt_q <= 3'd0;
              if (rw_q) begin
                sh_q     <= bus.tx_data[6:0];
                sda_oe_q <= ~bus.tx_data[7];
                state_q  <= S_RD_DATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= S_WR_DATA;
              end
            end
          end
          S_WR_DATA: begin
            if (scl_rise && !byte_q) begin
              sh_q  <= {sh_q[5:0], sda_s};
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                rx_data_q  <= {sh_q, sda_s};
                rx_valid_q <= 1'b1;
                byte_q     <= 1'b1;
              end
            end else if (scl_fall && byte_q) begin
              byte_q   <= 1'b0;
              sda_oe_q <= 1'b1;
              state_q  <= S_WR_ACK;
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= S_WR_DATA;
            end
          end
          S_RD_DATA: begin
            if (scl_fall) begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                sda_oe_q <= 1'b0;
                tx_req_q <= 1'b1;
                state_q  <= S_RD_ACK;
              end else begin
                sda_oe_q <= ~sh_q[6];
                sh_q     <= {sh_q[5:0], 1'b0};
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise && sda_s) begin
              // Master NACK: abandon and wait for STOP/START.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (scl_fall) begin
              cnt_q    <= 3'd0;
              sh_q     <= bus.tx_data[6:0];
              sda_oe_q <= ~bus.tx_data[7];
              state_q  <= S_RD_DATA;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.start_det = start_det_q;
  assign bus.stop_det  = stop_det_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C master model, scoreboard of expected
// received bytes checked by a monitor thread, tx byte source fed on tx_req.
module tb_i2c_target;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  i2c_target_if bus();

  i2c_target #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;   // wired-AND open-drain line

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0, stop_cnt = 0, txreq_cnt = 0;
  int exp_start = 0, exp_stop = 0;
  logic oe_seen = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_src[$];

  logic       ackb, got, m_ok, m_rw;
  logic [7:0] rbyte, abyte;
  logic [6:0] a7;
  logic [7:0] dat[4];
  int         nb, base;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic half_p();
    repeat ($urandom_range(6, 10)) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      sda_m = 1'b1; half_p();
      scl_m = 1'b1; half_p();
    end
    sda_m = 1'b0; half_p();
    scl_m = 1'b0; half_p();
    exp_start++;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; half_p();
    scl_m = 1'b1; half_p();
    sda_m = 1'b1; half_p();
    exp_stop++;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    half_p();
    scl_m = 1'b1; half_p();
    scl_m = 1'b0; half_p();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; half_p();
    scl_m = 1'b1; half_p();
    @(negedge clk);
    b = bus.sda_i;
    scl_m = 1'b0; half_p();
  endtask

  // Returns 1 when the target acknowledged.
  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~m_ack);
  endtask

  initial begin
    bus.tx_data = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_pulses", {bus.rx_valid, bus.tx_req, bus.start_det, bus.stop_det}, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    fork
      // Monitor: pulse counters, tx byte source, rx scoreboard.
      forever begin
        @(negedge clk);
        if (bus.start_det) start_cnt++;
        if (bus.stop_det)  stop_cnt++;
        if (bus.sda_oe)    oe_seen = 1'b1;
        if (bus.tx_req) begin
          txreq_cnt++;
          bus.tx_data = (tx_src.size() != 0) ? tx_src.pop_front() : 8'hEE;
        end
        if (bus.rx_valid) begin
          if (exp_rx.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_unexpected: got %0h expected none", bus.rx_data);
          end else begin
            chk("rx_data", bus.rx_data, exp_rx.pop_front());
          end
        end
      end
      begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Write with matching address.
    i2c_start();
    write_byte(8'hA0, ackb); chk("t1_addr_ack", ackb, 1);
    exp_rx.push_back(8'hA5);
    write_byte(8'hA5, ackb); chk("t1_data_ack", ackb, 1);
    i2c_stop();
    chk("t1_busy", bus.busy, 0);
    chk("t1_rx_drain", exp_rx.size(), 0);
    chk("t1_starts", start_cnt, exp_start);
    chk("t1_stops", stop_cnt, exp_stop);

    // Wrong address: target stays silent.
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h84, ackb); chk("t2_addr_ack", ackb, 0);
    chk("t2_busy", bus.busy, 0);
    write_byte(8'hA5, ackb); chk("t2_data_ack", ackb, 0);
    i2c_stop();
    chk("t2_oe_seen", oe_seen, 0);

    // Read two bytes, ACK then NACK.
    tx_src.delete();
    tx_src.push_back(8'h3C); tx_src.push_back(8'hC3);
    base = txreq_cnt;
    i2c_start();
    write_byte(8'hA1, ackb); chk("t3_addr_ack", ackb, 1);
    chk("t3_txreq1", txreq_cnt - base, 1);
    read_byte(1'b1, rbyte); chk("t3_byte1", rbyte, 8'h3C);
    chk("t3_txreq2", txreq_cnt - base, 2);
    read_byte(1'b0, rbyte); chk("t3_byte2", rbyte, 8'hC3);
    chk("t3_idle_after_nack", bus.busy, 0);
    i2c_stop();

    // Multi-byte write then repeated START into a read.
    i2c_start();
    write_byte(8'hA0, ackb); chk("t4_addr_ack", ackb, 1);
    for (int i = 1; i <= 3; i++) begin
      exp_rx.push_back(8'(i));
      write_byte(8'(i), ackb); chk("t4_data_ack", ackb, 1);
    end
    chk("t4_rx_drain", exp_rx.size(), 0);
    tx_src.delete(); tx_src.push_back(8'h5A);
    i2c_start();
    chk("t4_rstart", start_cnt, exp_start);
    write_byte(8'hA1, ackb); chk("t4_rd_ack", ackb, 1);
    read_byte(1'b0, rbyte); chk("t4_rd_byte", rbyte, 8'h5A);
    i2c_stop();

    // STOP after 4 data bits: no byte delivered.
    i2c_start();
    write_byte(8'hA0, ackb); chk("t5_addr_ack", ackb, 1);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    i2c_stop();
    chk("t5_busy", bus.busy, 0);
    chk("t5_sda_oe", bus.sda_oe, 0);
    chk("t5_stops", stop_cnt, exp_stop);

    // Reset while the target holds SDA in the address ACK slot.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);  // 0xA0
    for (int i = 0; i < 50 && !bus.sda_oe; i++) @(negedge clk);
    chk("t6_pre_oe", bus.sda_oe, 1);
    rst = 1'b0;
    #1;
    chk("t6_oe_async", bus.sda_oe, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_rx_data", bus.rx_data, 8'h00);
    chk("t6_pulses", {bus.rx_valid, bus.tx_req, bus.start_det, bus.stop_det}, 0);
    sda_m = 1'b1; scl_m = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    i2c_start();
    write_byte(8'hA0, ackb); chk("t6_addr_ack", ackb, 1);
    exp_rx.push_back(8'h99);
    write_byte(8'h99, ackb); chk("t6_data_ack", ackb, 1);
    i2c_stop();

    // Randomized transactions against a transaction-level model.
    for (int t = 0; t < 16; t++) begin
      a7   = ($urandom_range(0, 1) != 0) ? 7'h50 : 7'($urandom_range(0, 127));
      m_rw = 1'($urandom_range(0, 1));
      m_ok = (a7 == 7'h50);
      nb   = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) dat[k] = 8'($urandom);
      abyte = {a7, m_rw};
      if (!m_rw) begin
        i2c_start();
        write_byte(abyte, ackb); chk("rnd_wr_addr_ack", ackb, m_ok);
        for (int k = 0; k < nb; k++) begin
          if (m_ok) exp_rx.push_back(dat[k]);
          write_byte(dat[k], ackb); chk("rnd_wr_data_ack", ackb, m_ok);
        end
        i2c_stop();
        chk("rnd_wr_drain", exp_rx.size(), 0);
      end else begin
        tx_src.delete();
        if (m_ok) for (int k = 0; k < nb; k++) tx_src.push_back(dat[k]);
        base = txreq_cnt;
        i2c_start();
        write_byte(abyte, ackb); chk("rnd_rd_addr_ack", ackb, m_ok);
        for (int k = 0; k < nb; k++) begin
          if (m_ok) chk("rnd_txreq", txreq_cnt - base, k + 1);
          read_byte(k != nb - 1, rbyte);
          chk("rnd_rd_byte", rbyte, m_ok ? dat[k] : 8'hFF);
        end
        i2c_stop();
      end
      chk("rnd_busy", bus.busy, 0);
    end
    chk("end_starts", start_cnt, exp_start);
    chk("end_stops", stop_cnt, exp_stop);
    chk("end_rx_drain", exp_rx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
